axi_id_timeout_tracker: RTL

Per-ID outstanding-transaction tracker with watchdog timeouts for one AXI direction (AR/R or AW/B), sitting beside the monitor's ID remapper on the slave side. It holds up to `MaxUniqIds` distinct IDs, each with up to `MaxTxnsPerId` outstanding transactions. It also:
- stalls new requests when capacity is exhausted;
- reloads a per-ID budget timer on response progress;
- reports each ID whose timer expires, one report per cycle;
- flags responses that match no tracked ID.

---
 rtl/axi_id_timeout_tracker.sv | 125 ++++++++++++
 1 files changed

// File: rtl/axi_id_timeout_tracker.sv
// axi_id_timeout_tracker: per-ID outstanding-transaction table with watchdog timeouts,
// capacity stall and unexpected-response detection for one AXI direction.
module axi_id_timeout_tracker #(
  parameter int MaxUniqIds   = 4,
  parameter int MaxTxnsPerId = 12,
  parameter int CntWidth     = 10,
  parameter int IdWidth      = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [CntWidth-1:0] budget_i,
  input  logic                req_valid_i,
  input  logic                req_ready_i,
  input  logic [IdWidth-1:0]  req_id_i,
  input  logic                rsp_valid_i,
  input  logic                rsp_ready_i,
  input  logic                rsp_last_i,
  input  logic [IdWidth-1:0]  rsp_id_i,
  output logic                stall_o,
  output logic                timeout_o,
  output logic [IdWidth-1:0]  timeout_id_o,
  output logic                err_unexpected_o,
  output logic                busy_o
);
  localparam int CW = $clog2(MaxTxnsPerId + 1);
  localparam int IW = MaxUniqIds > 1 ? $clog2(MaxUniqIds) : 1;
  logic [MaxUniqIds-1:0] valid, expired, reported;
  logic [IdWidth-1:0]    id    [MaxUniqIds];
  logic [CW-1:0]         cnt   [MaxUniqIds];
  logic [CW-1:0]         cnt_n [MaxUniqIds];
  logic [CntWidth-1:0]   timer [MaxUniqIds];
  logic [MaxUniqIds-1:0] req_hit, rsp_hit, pend, rep_sel;
  logic [MaxUniqIds-1:0] inc, dec, alloc, rl, dn, valid_n;
  logic [IW-1:0]         req_idx, rsp_idx, free_idx, rep_idx;
  logic                  req_match, rsp_match, req_fire, rsp_fire, req_acc;
  // Downward scans leave the lowest matching index in each *_idx.
  always_comb begin
    req_hit = '0;
    rsp_hit = '0;
    pend = '0;
    rep_sel = '0;
    req_idx = '0;
    rsp_idx = '0;
    free_idx = '0;
    rep_idx = '0;
    for (int k = MaxUniqIds - 1; k >= 0; k--) begin
      req_hit[k] = valid[k] && (id[k] == req_id_i);
      rsp_hit[k] = valid[k] && (id[k] == rsp_id_i);
      pend[k] = expired[k] & ~reported[k];
      if (req_hit[k]) req_idx = IW'(k);
      if (rsp_hit[k]) rsp_idx = IW'(k);
      if (!valid[k]) free_idx = IW'(k);
      if (pend[k]) rep_idx = IW'(k);
    end
    rep_sel[rep_idx] = |pend;
  end
  assign req_match = |req_hit;
  assign rsp_match = |rsp_hit;
  assign req_fire  = req_valid_i & req_ready_i;
  assign rsp_fire  = rsp_valid_i & rsp_ready_i;
  assign stall_o   = req_match ? (cnt[req_idx] == CW'(MaxTxnsPerId)) : &valid;
  assign req_acc   = req_fire & ~stall_o;
  // Allocation targets a slot that is free in the current state, so a slot freed this cycle waits.
  always_comb begin
    inc = '0;
    dec = '0;
    alloc = '0;
    rl = '0;
    dn = '0;
    valid_n = '0;
    for (int k = 0; k < MaxUniqIds; k++) begin
      inc[k] = req_acc & req_hit[k];
      dec[k] = rsp_fire & rsp_hit[k] & rsp_last_i;
      alloc[k] = req_acc & ~req_match & (free_idx == IW'(k));
      rl[k] = inc[k] | (rsp_fire & rsp_hit[k]);
      dn[k] = enable_i & ~rl[k] & (timer[k] != '0);
      cnt_n[k] = cnt[k] + CW'(inc[k]) - CW'(dec[k]);
      valid_n[k] = alloc[k] | (valid[k] & (cnt_n[k] != '0));
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < MaxUniqIds; k++) begin
        valid[k] <= 1'b0;
        id[k] <= '0;
        cnt[k] <= '0;
        timer[k] <= '0;
        expired[k] <= 1'b0;
        reported[k] <= 1'b0;
      end
      timeout_o <= 1'b0;
      timeout_id_o <= '0;
      err_unexpected_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      for (int k = 0; k < MaxUniqIds; k++) begin
        if (alloc[k]) begin
          valid[k] <= 1'b1;
          id[k] <= req_id_i;
          cnt[k] <= CW'(1);
          timer[k] <= budget_i;
          expired[k] <= 1'b0;
          reported[k] <= 1'b0;
        end else if (!valid_n[k]) begin
          valid[k] <= 1'b0;
          id[k] <= '0;
          cnt[k] <= '0;
          timer[k] <= '0;
          expired[k] <= 1'b0;
          reported[k] <= 1'b0;
        end else begin
          cnt[k] <= cnt_n[k];
          timer[k] <= rl[k] ? budget_i : timer[k] - CntWidth'(dn[k]);
          expired[k] <= expired[k] | (dn[k] & (timer[k] == CntWidth'(1)));
          reported[k] <= reported[k] | rep_sel[k];
        end
      end
      timeout_o <= |pend;
      timeout_id_o <= |pend ? id[rep_idx] : '0;
      err_unexpected_o <= (req_fire & stall_o) | (rsp_fire & ~rsp_match);
      busy_o <= |valid_n;
    end
  end
endmodule
